// File: rtl/processing_unit_if.sv
// rtl/processing_unit_if.sv - control strobes, memory data and datapath outputs of processing_unit
interface processing_unit_if #(
  parameter int word_size = 8,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
);
  logic                 Load_R0;
  logic                 Load_R1;
  logic                 Load_R2;
  logic                 Load_R3;
  logic                 Load_PC;
  logic                 Inc_PC;
  logic                 Load_IR;
  logic                 Load_Add_R;
  logic                 Load_Reg_Y;
  logic                 Load_Reg_Z;
  logic [Sel1_size-1:0] Sel_Bus_1_Mux;
  logic [Sel2_size-1:0] Sel_Bus_2_Mux;
  logic [word_size-1:0] mem_word;
  logic [word_size-1:0] instruction;
  logic                 zero;
  logic [word_size-1:0] address;
  logic [word_size-1:0] bus_1;

  modport master (
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
           Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
    input  instruction, zero, address, bus_1
  );

  modport slave (
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
           Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
    output instruction, zero, address, bus_1
  );
endinterface

// File: rtl/processing_unit.sv
// rtl/processing_unit.sv - register file, PC, IR, Add_R, Reg_Y/Reg_Z, ALU and bus muxes
module processing_unit #(
  parameter int word_size = 8,
  parameter int op_size   = 4,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
) (
  input  logic             clk,
  input  logic             rst,
  processing_unit_if.slave pu
);
  localparam logic [Sel1_size-1:0] SEL1_R0 = Sel1_size'(0);
  localparam logic [Sel1_size-1:0] SEL1_R1 = Sel1_size'(1);
  localparam logic [Sel1_size-1:0] SEL1_R2 = Sel1_size'(2);
  localparam logic [Sel1_size-1:0] SEL1_R3 = Sel1_size'(3);
  localparam logic [Sel1_size-1:0] SEL1_PC = Sel1_size'(4);

  localparam logic [Sel2_size-1:0] SEL2_ALU = Sel2_size'(0);
  localparam logic [Sel2_size-1:0] SEL2_B1  = Sel2_size'(1);
  localparam logic [Sel2_size-1:0] SEL2_MEM = Sel2_size'(2);

  localparam logic [op_size-1:0] OP_ADD  = op_size'(1);
  localparam logic [op_size-1:0] OP_SUB  = op_size'(2);
  localparam logic [op_size-1:0] OP_AND  = op_size'(3);
  localparam logic [op_size-1:0] OP_NOT  = op_size'(4);
  localparam logic [op_size-1:0] OP_SHL  = op_size'(9);
  localparam logic [op_size-1:0] OP_SHR  = op_size'(10);
  localparam logic [op_size-1:0] OP_SUBT = op_size'(11);

  logic [word_size-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [word_size-1:0] pc_q, pc_d, ir_q, ir_d, add_r_q, add_r_d, reg_y_q, reg_y_d;
  logic                 reg_z_q, reg_z_d;

  logic [word_size-1:0] bus_1, bus_2, alu_out;
  logic [op_size-1:0]   opcode;

  assign opcode = ir_q[word_size-1 -: op_size];

  // Unlisted and unknown select codes fall to the default arm and drive 0.
  always_comb begin
    bus_1 = '0;
    case (pu.Sel_Bus_1_Mux)
      SEL1_R0: bus_1 = r0_q;
      SEL1_R1: bus_1 = r1_q;
      SEL1_R2: bus_1 = r2_q;
      SEL1_R3: bus_1 = r3_q;
      SEL1_PC: bus_1 = pc_q;
      default: bus_1 = '0;
    endcase
  end

  always_comb begin
    bus_2 = '0;
    case (pu.Sel_Bus_2_Mux)
      SEL2_ALU: bus_2 = alu_out;
      SEL2_B1:  bus_2 = bus_1;
      SEL2_MEM: bus_2 = pu.mem_word;
      default:  bus_2 = '0;
    endcase
  end

  // data_1 is Reg_Y, data_2 is Bus_1; word-width results drop carries and borrows.
  always_comb begin
    alu_out = '0;
    case (opcode)
      OP_ADD:  alu_out = reg_y_q + bus_1;
      OP_SUB:  alu_out = bus_1 - reg_y_q;
      OP_AND:  alu_out = reg_y_q & bus_1;
      OP_NOT:  alu_out = ~bus_1;
      OP_SHL:  alu_out = reg_y_q << 1;
      OP_SHR:  alu_out = reg_y_q >> 1;
      OP_SUBT: alu_out = reg_y_q - bus_1;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    r0_d    = pu.Load_R0    ? bus_2 : r0_q;
    r1_d    = pu.Load_R1    ? bus_2 : r1_q;
    r2_d    = pu.Load_R2    ? bus_2 : r2_q;
    r3_d    = pu.Load_R3    ? bus_2 : r3_q;
    ir_d    = pu.Load_IR    ? bus_2 : ir_q;
    add_r_d = pu.Load_Add_R ? bus_2 : add_r_q;
    reg_y_d = pu.Load_Reg_Y ? bus_2 : reg_y_q;
    reg_z_d = pu.Load_Reg_Z ? (alu_out == '0) : reg_z_q;
    pc_d    = pc_q;
    if (pu.Load_PC) begin
      pc_d = bus_2;
    end else if (pu.Inc_PC) begin
      pc_d = pc_q + word_size'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      add_r_q <= '0;
      reg_y_q <= '0;
      reg_z_q <= 1'b0;
    end else begin
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      add_r_q <= add_r_d;
      reg_y_q <= reg_y_d;
      reg_z_q <= reg_z_d;
    end
  end

  assign pu.instruction = ir_q;
  assign pu.zero        = reg_z_q;
  assign pu.address     = add_r_q;
  assign pu.bus_1       = bus_1;
endmodule

// File: tb/tb_processing_unit.sv
// tb/tb_processing_unit.sv - randomized and directed bench for processing_unit
module tb_processing_unit;
  localparam logic [9:0] L_R0 = 10'h001, L_R1 = 10'h002, L_R2 = 10'h004, L_R3 = 10'h008;
  localparam logic [9:0] L_PC = 10'h010, L_INC = 10'h020, L_IR = 10'h040;
  localparam logic [9:0] L_ADDR = 10'h080, L_Y = 10'h100, L_Z = 10'h200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  processing_unit_if pif ();
  processing_unit dut (.clk(clk), .rst(rst), .pu(pif));

  logic [7:0] mem [256];
  assign pif.mem_word = mem[pif.address];

  logic [7:0] m_r [4];
  logic [7:0] m_pc, m_ir, m_addr, m_y;
  logic       m_z;
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [7:0] m_bus1(input logic [2:0] s);
    if (s < 3'd4) return m_r[s[1:0]];
    if (s == 3'd4) return m_pc;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_alu(input logic [3:0] op, input logic [7:0] y, input logic [7:0] b);
    int a, c, r;
    a = int'(y);
    c = int'(b);
    case (op)
      4'd1:  r = (a + c) % 256;
      4'd2:  r = (c - a + 256) % 256;
      4'd3:  r = int'(y & b);
      4'd4:  r = 255 - c;
      4'd9:  r = (a * 2) % 256;
      4'd10: r = a / 2;
      4'd11: r = (a - c + 256) % 256;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 0; m_ir = 0; m_addr = 0; m_y = 0; m_z = 0;
  endtask

  task automatic drive(input logic [9:0] ld, input logic [2:0] s1, input logic [1:0] s2);
    pif.Load_R0 = ld[0]; pif.Load_R1 = ld[1]; pif.Load_R2 = ld[2]; pif.Load_R3 = ld[3];
    pif.Load_PC = ld[4]; pif.Inc_PC = ld[5]; pif.Load_IR = ld[6];
    pif.Load_Add_R = ld[7]; pif.Load_Reg_Y = ld[8]; pif.Load_Reg_Z = ld[9];
    pif.Sel_Bus_1_Mux = s1;
    pif.Sel_Bus_2_Mux = s2;
  endtask

  task automatic do_cycle(input logic [9:0] ld, input logic [2:0] s1, input logic [1:0] s2);
    logic [7:0] b1, b2, alu;
    drive(ld, s1, s2);
    b1  = m_bus1(s1);
    alu = m_alu(m_ir[7:4], m_y, b1);
    b2  = (s2 == 2'd0) ? alu : (s2 == 2'd1) ? b1 : (s2 == 2'd2) ? mem[m_addr] : 8'h00;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (ld[i]) m_r[i] = b2;
    if (ld[4]) m_pc = b2;
    else if (ld[5]) m_pc = m_pc + 8'd1;
    if (ld[6]) m_ir = b2;
    if (ld[7]) m_addr = b2;
    if (ld[8]) m_y = b2;
    if (ld[9]) m_z = (alu == 8'h00);
    drive(10'h000, s1, s2);
  endtask

  task automatic load_val(input logic [9:0] ld, input logic [7:0] v);
    mem[m_addr] = v;
    do_cycle(ld, 3'd0, 2'd2);
  endtask

  task automatic peek(input logic [2:0] s1, output logic [7:0] v);
    pif.Sel_Bus_1_Mux = s1;
    #1;
    v = pif.bus_1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    drive(10'h000, 3'd0, 2'd0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (pif.instruction !== 8'h00) $display("FAIL reset_ir got %h want 00", pif.instruction); else n_pass++;
    n_total++; if (pif.zero !== 1'b0) $display("FAIL reset_zero got %b want 0", pif.zero); else n_pass++;
    n_total++; if (pif.address !== 8'h00) $display("FAIL reset_addr got %h want 00", pif.address); else n_pass++;
    for (int s = 0; s < 5; s++) begin
      peek(3'(s), v);
      n_total++; if (v !== 8'h00) $display("FAIL reset_bus1_sel%0d got %h want 00", s, v); else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [7:0] v;
    mem[0] = 8'h16;
    do_cycle(L_ADDR, 3'd4, 2'd1);
    n_total++; if (pif.address !== 8'h00) $display("FAIL fetch_addr got %h want 00", pif.address); else n_pass++;
    do_cycle(L_IR | L_INC, 3'd4, 2'd2);
    n_total++; if (pif.instruction !== 8'h16) $display("FAIL fetch_ir got %h want 16", pif.instruction); else n_pass++;
    peek(3'd4, v);
    n_total++; if (v !== 8'h01) $display("FAIL fetch_pc got %h want 01", v); else n_pass++;
  endtask

  task automatic test_add();
    logic [7:0] v;
    load_val(L_R1, 8'd5);
    load_val(L_R2, 8'd3);
    do_cycle(L_Y, 3'd1, 2'd1);
    do_cycle(L_R2 | L_Z, 3'd2, 2'd0);
    peek(3'd2, v);
    n_total++; if (v !== 8'h08) $display("FAIL add_r2 got %h want 08", v); else n_pass++;
    n_total++; if (pif.zero !== 1'b0) $display("FAIL add_zero got %b want 0", pif.zero); else n_pass++;
  endtask

  task automatic test_sub_zero();
    logic [7:0] v;
    load_val(L_R3, 8'd7);
    load_val(L_Y, 8'd7);
    load_val(L_IR, 8'h2F);
    do_cycle(L_R3 | L_Z, 3'd3, 2'd0);
    peek(3'd3, v);
    n_total++; if (v !== 8'h00) $display("FAIL sub_r3 got %h want 00", v); else n_pass++;
    n_total++; if (pif.zero !== 1'b1) $display("FAIL sub_zero got %b want 1", pif.zero); else n_pass++;
    do_cycle(L_R0, 3'd1, 2'd1);
    n_total++; if (pif.zero !== 1'b1) $display("FAIL zero_hold got %b want 1", pif.zero); else n_pass++;
  endtask

  task automatic test_pc();
    logic [7:0] v;
    load_val(L_PC, 8'hFF);
    do_cycle(L_INC, 3'd4, 2'd0);
    peek(3'd4, v);
    n_total++; if (v !== 8'h00) $display("FAIL pc_wrap got %h want 00", v); else n_pass++;
    mem[m_addr] = 8'h40;
    do_cycle(L_PC | L_INC, 3'd4, 2'd2);
    peek(3'd4, v);
    n_total++; if (v !== 8'h40) $display("FAIL pc_priority got %h want 40", v); else n_pass++;
  endtask

  task automatic test_shift_not();
    logic [7:0] v;
    load_val(L_Y, 8'h81);
    load_val(L_R0, 8'h0F);
    load_val(L_IR, 8'h90);
    do_cycle(L_R1, 3'd0, 2'd0);
    peek(3'd1, v);
    n_total++; if (v !== 8'h02) $display("FAIL shl got %h want 02", v); else n_pass++;
    load_val(L_IR, 8'hA0);
    do_cycle(L_R1, 3'd0, 2'd0);
    peek(3'd1, v);
    n_total++; if (v !== 8'h40) $display("FAIL shr got %h want 40", v); else n_pass++;
    load_val(L_IR, 8'h40);
    do_cycle(L_R1, 3'd0, 2'd0);
    peek(3'd1, v);
    n_total++; if (v !== 8'hF0) $display("FAIL not got %h want f0", v); else n_pass++;
  endtask

  task automatic test_midop_reset();
    logic [7:0] v;
    load_val(L_IR, 8'h5A);
    load_val(L_R2, 8'h77);
    mem[m_addr] = 8'h3C;
    drive(L_IR | L_R2, 3'd0, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (pif.instruction !== 8'h00) $display("FAIL midrst_ir got %h want 00", pif.instruction); else n_pass++;
    peek(3'd2, v);
    n_total++; if (v !== 8'h00) $display("FAIL midrst_r2 got %h want 00", v); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (pif.instruction !== 8'h00) $display("FAIL midrst_edge_ir got %h want 00", pif.instruction); else n_pass++;
    drive(10'h000, 3'd0, 2'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    load_val(L_R0, 8'h33);
    peek(3'd6, v);
    n_total++; if (v !== 8'h00) $display("FAIL sel1_illegal got %h want 00", v); else n_pass++;
    do_cycle(L_R0, 3'd0, 2'd3);
    peek(3'd0, v);
    n_total++; if (v !== 8'h00) $display("FAIL sel2_illegal got %h want 00", v); else n_pass++;
  endtask

  task automatic test_random();
    logic [9:0] ld;
    logic [7:0] v, e;
    logic [2:0] s;
    for (int n = 0; n < 400; n++) begin
      ld = '0;
      for (int b = 0; b < 10; b++) ld[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) mem[m_addr] = 8'($urandom);
      do_cycle(ld, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      n_total++; if (pif.instruction !== m_ir) $display("FAIL rnd_ir cyc %0d got %h want %h", n, pif.instruction, m_ir); else n_pass++;
      n_total++; if (pif.zero !== m_z) $display("FAIL rnd_zero cyc %0d got %b want %b", n, pif.zero, m_z); else n_pass++;
      n_total++; if (pif.address !== m_addr) $display("FAIL rnd_addr cyc %0d got %h want %h", n, pif.address, m_addr); else n_pass++;
      s = 3'($urandom_range(0, 7));
      peek(s, v);
      e = m_bus1(s);
      n_total++; if (v !== e) $display("FAIL rnd_bus1 cyc %0d sel %0d got %h want %h", n, s, v, e); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    drive(10'h000, 3'd0, 2'd0);
    test_reset();
    test_fetch();
    test_add();
    test_sub_zero();
    test_pc();
    test_shift_not();
    test_midop_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/processing_unit.md
Name: processing_unit

Overview:
- Datapath that consumes every control strobe from the control unit and returns `instruction` (IR contents) and `zero` (Z flag) to it.
- Holds the register file R0–R3, PC, IR, address register Add_R, ALU operand register Reg_Y, zero-flag register Reg_Z, the ALU, and the two bus multiplexers.
- Drives the memory address and write data. Memory read data returns combinationally on `mem_word`.

Parameters:
- word_size, 8, width of every register, bus and memory word.
- op_size, 4, opcode field width; opcode = IR[word_size-1 : word_size-op_size].
- Sel1_size, 3, width of the Bus_1 mux select.
- Sel2_size, 2, width of the Bus_2 mux select.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Load_R0, Load_R1, Load_R2, Load_R3  in  1 each  load Rn from Bus_2.
- Load_PC  in  1  load PC from Bus_2.
- Inc_PC  in  1  increment PC.
- Load_IR  in  1  load IR from Bus_2.
- Load_Add_R  in  1  load Add_R from Bus_2.
- Load_Reg_Y  in  1  load Reg_Y from Bus_2.
- Load_Reg_Z  in  1  load Reg_Z from the ALU zero detect.
- Sel_Bus_1_Mux  in  Sel1_size  Bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
- Sel_Bus_2_Mux  in  Sel2_size  Bus_2 source: 0=alu_out, 1=Bus_1, 2=mem_word.
- mem_word  in  word_size  memory read data for `address`.
- instruction  out  word_size  IR contents.
- zero  out  1  Reg_Z contents.
- address  out  word_size  Add_R contents.
- bus_1  out  word_size  Bus_1 value; this is the memory write data.

Behaviour:
- Reset: rst=1 asynchronously clears R0–R3, PC, IR, Add_R and Reg_Y to 0, and Reg_Z to 0. Outputs therefore read instruction=0, zero=0, address=0. bus_1 follows the current select.
- Reset asserted mid-operation discards all pending loads in that cycle. The first edge after release behaves normally.
- Bus_1 (combinational): selects R0..R3 or PC per Sel_Bus_1_Mux. Codes 5–7 and X/Z give 0.
- Bus_2 (combinational): code 0=alu_out, 1=Bus_1, 2=mem_word. Code 3 and X/Z give 0.
- ALU (combinational): data_1 = Reg_Y, data_2 = Bus_1, opcode taken from IR. Results are truncated to word_size; carries and borrows are discarded.
  - ADD(1): data_1 + data_2.
  - SUB(2): data_2 − data_1.
  - AND(3): data_1 & data_2.
  - NOT(4): ~data_2.
  - SHL(9): data_1 << 1, LSB filled with 0.
  - SHR(10): data_1 >> 1, logical.
  - SUBT(11): data_1 − data_2.
  - All other opcodes: 0.
- Zero flag: on a clock edge with Load_Reg_Z=1, Reg_Z <= (alu_out == 0). Otherwise Reg_Z holds.
- Register loads: each register with its load strobe high captures Bus_2 on the rising edge; otherwise it holds.
  - Several strobes high in one cycle all capture the same Bus_2 value.
  - A register read onto Bus_1 and loaded in the same cycle captures the pre-edge value path (no combinational loop through the register).
- PC:
  - Load_PC=1: PC <= Bus_2. Load_PC has priority over Inc_PC.
  - Else Inc_PC=1: PC <= PC+1, wrapping 8'hFF to 8'h00.
  - Else PC holds.
  - Inc_PC together with Load_Add_R (read/write address phase) is legal. Add_R captures Bus_2 while PC increments.
- Latency:
  - Register updates are visible one cycle after the strobe.
  - instruction, zero and address are register outputs with no combinational path from inputs.
  - bus_1 is combinational from the select input and the registers.

Test Plan:
- Fetch: release rst, memory word at 0 = 8'h16. Cycle A: Sel1=4, Sel2=1, Load_Add_R. Cycle B: Sel2=2, Load_IR, Inc_PC. Required: address=0 after A; instruction=8'h16 and PC=1 after B.
- ADD: R1=5, R2=3, IR=8'h16. Load Reg_Y from R1 (Sel1=1, Sel2=1). Then Sel1=2, Sel2=0, Load_R2 and Load_Reg_Z. Required: R2=8, zero=0.
- SUB zero and flag hold: Reg_Y=7, R3=7, IR=8'h2F. Load_R3 and Load_Reg_Z → R3=0, zero=1. A following cycle without Load_Reg_Z keeps zero=1.
- PC wrap and priority: PC=8'hFF, Inc_PC → PC=0. Then Load_PC and Inc_PC together with mem_word=8'h40, Sel2=2 → PC=8'h40, not 8'h01.
- Shifts and NOT: Reg_Y=8'h81. SHL → 8'h02. SHR → 8'h40. NOT with Bus_1=R0=8'h0F → 8'hF0.
- Mid-op reset and illegal selects: assert rst during a cycle with Load_IR=1 → all registers 0 immediately, instruction=0. Sel1=6 → bus_1=0. Sel2=3 with Load_R0 → R0=0.
